adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Sequences ADC sample capture for the ADC_in datapath.
- Software arms the block.
- It waits for a programmable threshold crossing on the ADC bus, then captures a fixed-length, optionally decimated burst.
- The burst is streamed downstream over a valid/ready interface, with overflow reporting.
- Sits between the raw ADC input register stage and the LED/debug/DAC consumers.

Parameters:
DATA_W, 8, ADC sample width
LEN_W, 8, burst length counter width; burst_len=0 means 2^LEN_W samples
DEC_W, 4, decimation field width; keep 1 of every (decim+1) samples

Ports:
clk_pin_p  in  1  single system clock, all logic rising-edge
rst_pin  in  1  asynchronous, active-low reset
ADC_in  in  DATA_W  raw ADC sample bus, sampled every cycle
arm  in  1  pulse; starts a capture when the block is IDLE
abort  in  1  pulse; returns the block to IDLE from any state
trig_level  in  DATA_W  trigger threshold, unsigned
trig_rising  in  1  1 = rising crossing, 0 = falling crossing
burst_len  in  LEN_W  samples per burst; latched on arm
decim  in  DEC_W  decimation factor minus one; latched on arm
m_data  out  DATA_W  captured sample
m_valid  out  1  m_data valid
m_ready  in  1  downstream accept
m_last  out  1  marks the final sample of the burst
busy  out  1  high in ARMED, CAPTURE and DONE
overflow  out  1  sticky; a sample was dropped; cleared on accepted arm
state_out  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Behaviour:
- Reset (rst_pin low, async): state IDLE; m_data=0, m_valid=0, m_last=0, busy=0, overflow=0, state_out=0; pipeline registers 0.
- Input pipeline: adc_q<=ADC_in; adc_qq<=adc_q.
- Rising trigger: adc_qq<trig_level && adc_q>=trig_level.
- Falling trigger: adc_qq>=trig_level && adc_q<trig_level.
- IDLE: arm -> ARMED. Latch burst_len and decim, clear overflow, reset sample and decimation counters. arm is ignored in every other state.
- ARMED: on trigger -> CAPTURE. The triggering adc_q value is sample 0 (decimation phase 0) and is loaded in the same cycle.
- CAPTURE: decimation phase counts 0..decim and wraps; a sample is taken when phase==0.
- Taken sample, output slot free (m_valid==0, or m_valid&&m_ready this cycle): load m_data, set m_valid. Set m_last if it is the final sample.
- Taken sample, slot occupied: drop it, set overflow, still count it.
- After the burst_len-th taken sample -> DONE.
- A dropped final sample produces no m_last beat; overflow reports it.
- DONE: -> IDLE when no beat is pending (m_valid==0, or handshake this cycle).
- Handshake: m_data and m_last stay stable while m_valid && !m_ready. Beat transfers on m_valid && m_ready. m_valid deasserts the next cycle unless a new sample loads.
- Latency: ADC_in at edge t reaches adc_q at t+1. If sampled, it appears on m_data with m_valid at edge t+2.
- abort: any state -> IDLE next edge; m_valid and m_last cleared; overflow retained. abort beats arm and trigger in the same cycle.
- burst_len=0 produces 2^LEN_W samples. Counters wrap only through reload on arm.
- decim changes while busy have no effect, because the value is latched.

Optional Feature:
ADC_CAPT_TIMEOUT_EN
- Defined: adds parameter TMO_W=16, input tmo_cycles[TMO_W], output timed_out.
  - In ARMED, a counter increments each cycle.
  - When it reaches tmo_cycles (non-zero), a forced trigger fires and capture starts with the current adc_q.
  - timed_out is set sticky, cleared on arm.
  - tmo_cycles=0 disables the timeout.
- Undefined: ports and counter are absent; ARMED waits indefinitely.

Decomposition:
- Shared package adc_capt_pkg holds:
  - state encoding constants (IDLE/ARMED/CAPTURE/DONE)
  - default DATA_W, LEN_W, DEC_W
- One sub-module, adc_trig_detect: adc_q/adc_qq registers plus the crossing compare. Outputs trig and adc_q.

Test Plan:
- Ramp 0x7E,0x7F,0x80,... with level=0x80, rising, burst_len=4, decim=0, m_ready=1 -> beats 0x80,0x81,0x82,0x83; m_last on 0x83; overflow=0; state returns to IDLE.
- Same ramp with decim=2 -> beats 0x80,0x83,0x86,0x89; m_last on 0x89.
- m_ready=0 throughout, burst_len=4 -> m_data holds 0x80 stably and overflow=1. State stays in DONE until m_ready=1, then one beat (m_last=0) transfers and the block goes to IDLE.
- Falling trigger at level=0x40, burst_len=0, decim=0 -> exactly 256 beats, m_last only on the 256th.
- abort during CAPTURE after 2 beats, with arm asserted the same cycle -> IDLE next edge, m_valid=0, no further beats. A fresh arm later captures a full burst.
- rst_pin low mid-CAPTURE -> all outputs 0 immediately. With the macro defined: no trigger and tmo_cycles=10 -> capture starts 10 cycles after ARMED, timed_out=1.

Source files
------------

// File: rtl/adc_capt_pkg.sv
// Shared state encoding and default widths for the ADC capture controller.
package adc_capt_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 8;
   localparam int DEF_DEC_W  = 4;
   localparam int DEF_TMO_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } capt_state_t;

endpackage

// File: rtl/adc_trig_detect.sv
// Two-stage ADC input pipeline and threshold crossing detector.
module adc_trig_detect
   import adc_capt_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] adc_in,
   input  logic [DATA_W-1:0] level,
   input  logic              rising,
   output logic              trig,
   output logic [DATA_W-1:0] adc_q
);

   logic [DATA_W-1:0] adc_qq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adc_q  <= '0;
         adc_qq <= '0;
      end else begin
         adc_q  <= adc_in;
         adc_qq <= adc_q;
      end
   end

   // adc_qq is the older sample; a crossing is the pair straddling the level.
   always_comb begin
      if (rising) trig = (adc_qq < level) && (adc_q >= level);
      else        trig = (adc_qq >= level) && (adc_q < level);
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Armed, threshold-triggered burst capture with decimation and valid/ready output.
// Optional forced-trigger timeout in ARMED is enabled by defining ADC_CAPT_TIMEOUT_EN.
module adc_capture_ctrl
   import adc_capt_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int DEC_W  = DEF_DEC_W
`ifdef ADC_CAPT_TIMEOUT_EN
   ,
   parameter int TMO_W  = DEF_TMO_W
`endif
) (
   input  logic              clk_pin_p,
   input  logic              rst_pin,
   input  logic [DATA_W-1:0] ADC_in,
   input  logic              arm,
   input  logic              abort,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [DEC_W-1:0]  decim,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              overflow,
`ifdef ADC_CAPT_TIMEOUT_EN
   input  logic [TMO_W-1:0]  tmo_cycles,
   output logic              timed_out,
`endif
   output logic [1:0]        state_out
);

   capt_state_t       state_reg, state_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              valid_reg, valid_next;
   logic              last_reg, last_next;
   logic              ovf_reg, ovf_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [LEN_W-1:0]  cnt_reg, cnt_next;
   logic [DEC_W-1:0]  dec_reg, dec_next;
   logic [DEC_W-1:0]  phase_reg, phase_next;
   logic [DATA_W-1:0] adc_q;
   logic              trig, trig_fire;
   logic              take, slot_free, is_final;

   adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
      .clk    (clk_pin_p),
      .rst_n  (rst_pin),
      .adc_in (ADC_in),
      .level  (trig_level),
      .rising (trig_rising),
      .trig   (trig),
      .adc_q  (adc_q)
   );

`ifdef ADC_CAPT_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             tmo_hit;
   logic             timed_out_reg;

   assign tmo_hit = (state_reg == ST_ARMED) && (tmo_cycles != '0) &&
                    (tmo_cnt_reg == TMO_W'(tmo_cycles - 1'b1));

   always_ff @(posedge clk_pin_p or negedge rst_pin) begin
      if (!rst_pin) begin
         tmo_cnt_reg   <= '0;
         timed_out_reg <= 1'b0;
      end else if (!abort) begin
         if (state_reg == ST_IDLE && arm) begin
            tmo_cnt_reg   <= '0;
            timed_out_reg <= 1'b0;
         end else if (state_reg == ST_ARMED) begin
            tmo_cnt_reg <= TMO_W'(tmo_cnt_reg + 1'b1);
            if (tmo_hit) timed_out_reg <= 1'b1;
         end
      end
   end

   assign trig_fire = trig | tmo_hit;
   assign timed_out = timed_out_reg;
`else
   assign trig_fire = trig;
`endif

   always_ff @(posedge clk_pin_p or negedge rst_pin) begin
      if (!rst_pin) begin
         state_reg <= ST_IDLE;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         len_reg   <= '0;
         cnt_reg   <= '0;
         dec_reg   <= '0;
         phase_reg <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         last_reg  <= last_next;
         ovf_reg   <= ovf_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         dec_reg   <= dec_next;
         phase_reg <= phase_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      valid_next = valid_reg;
      last_next  = last_reg;
      ovf_next   = ovf_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      dec_next   = dec_reg;
      phase_next = phase_reg;
      take       = 1'b0;
      slot_free  = !valid_reg || m_ready;
      // len_reg of zero wraps to all-ones, giving a 2^LEN_W burst.
      is_final   = (cnt_reg == LEN_W'(len_reg - 1'b1));

      if (valid_reg && m_ready) begin
         valid_next = 1'b0;
         last_next  = 1'b0;
      end

      case (state_reg)
         ST_IDLE: begin
            if (arm) begin
               state_next = ST_ARMED;
               len_next   = burst_len;
               dec_next   = decim;
               ovf_next   = 1'b0;
               cnt_next   = '0;
               phase_next = '0;
            end
         end
         ST_ARMED: begin
            if (trig_fire) begin
               take       = 1'b1;
               state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: take = (phase_reg == '0);
         ST_DONE: if (slot_free) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      if (state_reg == ST_CAPTURE || take)
         phase_next = (phase_reg == dec_reg) ? '0 : DEC_W'(phase_reg + 1'b1);

      if (take) begin
         if (slot_free) begin
            data_next  = adc_q;
            valid_next = 1'b1;
            last_next  = is_final;
         end else begin
            ovf_next = 1'b1;
         end
         cnt_next = LEN_W'(cnt_reg + 1'b1);
         if (is_final) state_next = ST_DONE;
      end

      if (abort) begin
         state_next = ST_IDLE;
         valid_next = 1'b0;
         last_next  = 1'b0;
         ovf_next   = ovf_reg;
      end
   end

   assign m_data    = data_reg;
   assign m_valid   = valid_reg;
   assign m_last    = last_reg;
   assign overflow  = ovf_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign state_out = state_reg;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl; the timeout case runs when ADC_CAPT_TIMEOUT_EN is defined.
module tb_adc_capture_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] adc_in, trig_level, burst_len, m_data;
   logic [3:0] decim;
   logic       arm, abort, trig_rising, m_ready;
   logic       m_valid, m_last, busy, overflow;
   logic [1:0] state_out;
`ifdef ADC_CAPT_TIMEOUT_EN
   logic [15:0] tmo_cycles;
   logic        timed_out;
`endif

   int         tests_run = 0;
   int         tests_failed = 0;
   logic       ramp_on;
   logic [7:0] ramp_step;
   logic [7:0] beat_data[$];
   logic       beat_last[$];

   always #5 clk = ~clk;

   adc_capture_ctrl dut (
      .clk_pin_p   (clk),
      .rst_pin     (rst_n),
      .ADC_in      (adc_in),
      .arm         (arm),
      .abort       (abort),
      .trig_level  (trig_level),
      .trig_rising (trig_rising),
      .burst_len   (burst_len),
      .decim       (decim),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .busy        (busy),
      .overflow    (overflow),
`ifdef ADC_CAPT_TIMEOUT_EN
      .tmo_cycles  (tmo_cycles),
      .timed_out   (timed_out),
`endif
      .state_out   (state_out)
   );

   // Inputs change 1 time unit after posedge, so negedge sees the handshake of the next edge.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         beat_data.push_back(m_data);
         beat_last.push_back(m_last);
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ramp_on) adc_in = adc_in + ramp_step;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic start_capture(input logic [7:0] start, input logic [7:0] lvl, input logic rising,
                                input logic [7:0] len, input logic [3:0] dc, input logic rdy);
      ramp_on     = 1'b0;
      adc_in      = start;
      trig_level  = lvl;
      trig_rising = rising;
      burst_len   = len;
      decim       = dc;
      m_ready     = rdy;
      beat_data.delete();
      beat_last.delete();
      run(2);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      ramp_on = 1'b1;
   endtask

   task automatic check_burst(input string tag, input int n, input logic [7:0] first, input logic [7:0] step);
      logic [7:0] e;
      check_value({tag, " count"}, beat_data.size(), n);
      for (int i = 0; i < n && i < beat_data.size(); i++) begin
         e = first + 8'(i) * step;
         check_value($sformatf("%s data[%0d]", tag, i), beat_data[i], e);
         check_value($sformatf("%s last[%0d]", tag, i), beat_last[i], (i == n - 1));
      end
   endtask

   initial begin
      int n;
      int data_err;
      int last_cnt;
      logic [7:0] e;

      rst_n = 1'b0; adc_in = 8'h00; trig_level = 8'h00; trig_rising = 1'b1;
      burst_len = 8'd0; decim = 4'd0; arm = 1'b0; abort = 1'b0; m_ready = 1'b1;
      ramp_on = 1'b0; ramp_step = 8'h01;
`ifdef ADC_CAPT_TIMEOUT_EN
      tmo_cycles = 16'd0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_value("rst m_valid", m_valid, 0);
      check_value("rst m_data", m_data, 0);
      check_value("rst m_last", m_last, 0);
      check_value("rst busy", busy, 0);
      check_value("rst overflow", overflow, 0);
      check_value("rst state", state_out, 0);
      rst_n = 1'b1;
      tick();

      // Rising ramp, no decimation
      start_capture(8'h7E, 8'h80, 1'b1, 8'd4, 4'd0, 1'b1);
      check_value("t1 armed state", state_out, 1);
      check_value("t1 armed busy", busy, 1);
      run(20);
      check_burst("t1", 4, 8'h80, 8'h01);
      check_value("t1 overflow", overflow, 0);
      check_value("t1 end state", state_out, 0);

      // Decimation keeps every third sample
      start_capture(8'h7E, 8'h80, 1'b1, 8'd4, 4'd2, 1'b1);
      run(30);
      check_burst("t2", 4, 8'h80, 8'h03);
      check_value("t2 end state", state_out, 0);

      // Downstream stalled: first sample held, rest dropped
      start_capture(8'h7E, 8'h80, 1'b1, 8'd4, 4'd0, 1'b0);
      run(20);
      check_value("t3 m_valid", m_valid, 1);
      check_value("t3 m_data", m_data, 8'h80);
      check_value("t3 m_last", m_last, 0);
      check_value("t3 overflow", overflow, 1);
      check_value("t3 state done", state_out, 3);
      run(3);
      check_value("t3 m_data hold", m_data, 8'h80);
      m_ready = 1'b1;
      tick();
      check_value("t3 beat count", beat_data.size(), 1);
      if (beat_data.size() > 0) begin
         check_value("t3 beat data", beat_data[0], 8'h80);
         check_value("t3 beat last", beat_last[0], 0);
      end
      check_value("t3 state idle", state_out, 0);
      check_value("t3 m_valid off", m_valid, 0);

      // Falling trigger, full 256-sample burst
      ramp_step = 8'hFF;
      start_capture(8'h42, 8'h40, 1'b0, 8'd0, 4'd0, 1'b1);
      run(280);
      ramp_step = 8'h01;
      check_value("t4 count", beat_data.size(), 256);
      data_err = 0;
      last_cnt = 0;
      for (int i = 0; i < beat_data.size(); i++) begin
         e = 8'h3F - 8'(i);
         if (beat_data[i] !== e) data_err++;
         if (beat_last[i]) last_cnt++;
      end
      check_value("t4 data errors", data_err, 0);
      check_value("t4 last count", last_cnt, 1);
      if (beat_data.size() == 256) check_value("t4 last on 256th", beat_last[255], 1);
      check_value("t4 overflow cleared", overflow, 0);
      check_value("t4 end state", state_out, 0);

      // Abort with simultaneous arm after two beats
      start_capture(8'h7E, 8'h80, 1'b1, 8'd8, 4'd0, 1'b1);
      for (int k = 0; k < 30 && beat_data.size() < 2; k++) tick();
      check_value("t5 beats before abort", beat_data.size(), 2);
      m_ready = 1'b0;
      abort = 1'b1;
      arm = 1'b1;
      tick();
      abort = 1'b0;
      arm = 1'b0;
      check_value("t5 state idle", state_out, 0);
      check_value("t5 m_valid", m_valid, 0);
      check_value("t5 m_last", m_last, 0);
      check_value("t5 busy", busy, 0);
      m_ready = 1'b1;
      run(20);
      check_value("t5 no more beats", beat_data.size(), 2);
      start_capture(8'h7E, 8'h80, 1'b1, 8'd8, 4'd0, 1'b1);
      run(25);
      check_burst("t5 rearm", 8, 8'h80, 8'h01);

      // Asynchronous reset mid-capture
      start_capture(8'h7E, 8'h80, 1'b1, 8'd8, 4'd0, 1'b0);
      for (int k = 0; k < 30 && state_out != 2; k++) tick();
      check_value("t6 in capture", state_out, 2);
      tick();
      check_value("t6 m_valid", m_valid, 1);
      check_value("t6 m_data", m_data, 8'h80);
      check_value("t6 overflow", overflow, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_value("t6 rst m_valid", m_valid, 0);
      check_value("t6 rst m_data", m_data, 0);
      check_value("t6 rst busy", busy, 0);
      check_value("t6 rst overflow", overflow, 0);
      check_value("t6 rst state", state_out, 0);
      ramp_on = 1'b0;
      tick();
      rst_n = 1'b1;
      m_ready = 1'b1;
      tick();

`ifdef ADC_CAPT_TIMEOUT_EN
      // Forced trigger after ten ARMED cycles with no crossing
      tmo_cycles = 16'd10;
      ramp_step = 8'h00;
      start_capture(8'h10, 8'h80, 1'b1, 8'd2, 4'd0, 1'b1);
      check_value("tmo armed", state_out, 1);
      check_value("tmo flag clear", timed_out, 0);
      n = 0;
      while (state_out == 1 && n < 50) begin
         tick();
         n++;
      end
      check_value("tmo cycles to capture", n, 10);
      check_value("tmo flag set", timed_out, 1);
      run(10);
      check_burst("tmo", 2, 8'h10, 8'h00);
      ramp_step = 8'h01;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
